fetch_buffer: RTL and testbench

//  - Instruction prefetch FIFO between the instruction-memory fetch stage and decode/control_unit.
//  - Decouples fetch from decode stalls: holds up to DEPTH {pc, instruction} pairs.
//  - Presents a NOP bubble to decode when empty.
//  - Supports single-cycle flush on branch/jump redirect.

---
 rtl/fetch_buffer.sv | 95 +++++++++
 tb/tb_fetch_buffer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction prefetch FIFO between fetch and decode
// Optional zero-latency pass-through when FETCH_BUF_BYPASS_EN is defined.
module fetch_buffer #(
  parameter int              DEPTH = 4,
  parameter int              XLEN  = 32,
  parameter logic [XLEN-1:0] NOP   = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic            do_write;
  logic            do_read;
  logic            bypass;

  // Pointers carry one extra wrap bit, so the difference is the occupancy.
  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == PW'(DEPTH));

`ifdef FETCH_BUF_BYPASS_EN
  assign bypass = empty & ~flush & in_valid;
`else
  assign bypass = 1'b0;
`endif

  assign in_ready  = ~full & ~flush;
  assign out_valid = (~empty & ~flush) | bypass;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // A bypassed instruction consumed this cycle never touches the array.
  assign do_write = push & ~(bypass & out_ready);
  assign do_read  = pop & ~bypass;

  always_comb begin
    out_pc    = '0;
    out_instr = NOP;
    if (bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end else if (out_valid) begin
      out_pc    = pc_mem[rd_ptr[AW-1:0]];
      out_instr = instr_mem[rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      pc_mem[wr_ptr[AW-1:0]]    <= in_pc;
      instr_mem[wr_ptr[AW-1:0]] <= in_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_read)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n && !flush) begin
      assert (!(do_read && empty)) else $error("fetch_buffer: pop while empty");
      assert (!(do_write && full)) else $error("fetch_buffer: push while full");
    end
  end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - directed self-checking bench for fetch_buffer
// Bypass-specific expectations follow FETCH_BUF_BYPASS_EN.
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int checks = 0;
  int errors = 0;

  fetch_buffer #(.DEPTH(4), .XLEN(32), .NOP(32'h0000_0013)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_pc = 32'h40; in_instr = 32'hdead;

    // 1. reset held two cycles with an offer present
    tick(); tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h13);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    reset_n = 1'b1; in_valid = 1'b0;

    // 2. fill then drain
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'(4 * i); in_instr = 32'h1000 + 32'(i);
      tick();
    end
    #1;
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_count", 32'(count), 32'd4);
    in_pc = 32'h10; in_instr = 32'h1004;
    tick();
    chk("fifth_count", 32'(count), 32'd4);
    chk("fifth_head", out_pc, 32'h0);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_pc", out_pc, 32'(4 * i));
      chk("drain_instr", out_instr, 32'h1000 + 32'(i));
      tick();
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_nop", out_instr, 32'h13);

    // 3. wrap with one entry in flight
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h200; in_instr = 32'h2000;
    tick();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      in_pc = 32'h204 + 32'(4 * i); in_instr = 32'h2001 + 32'(i);
      #1;
      chk("wrap_head", out_pc, 32'h200 + 32'(4 * i));
      chk("wrap_instr", out_instr, 32'h2000 + 32'(i));
      tick();
      chk("wrap_count", 32'(count), 32'd1);
      chk("wrap_full", 32'(full), 32'd0);
    end
    in_valid = 1'b0;
    tick();
    chk("wrap_empty", 32'(empty), 32'd1);

    // 4. push+pop while full: pop taken, push refused
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'h300 + 32'(4 * i); in_instr = 32'h3000 + 32'(i);
      tick();
    end
    in_pc = 32'h400; in_instr = 32'h4000; out_ready = 1'b1;
    #1;
    chk("pp_in_ready", 32'(in_ready), 32'd0);
    chk("pp_count_before", 32'(count), 32'd4);
    tick();
    chk("pp_head", out_pc, 32'h304);
    chk("pp_count_after", 32'(count), 32'd3);
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      #1;
      chk("pp_drain", out_pc, 32'h300 + 32'(4 * i));
      tick();
    end
    chk("pp_empty", 32'(empty), 32'd1);

    // 5. flush drops held entries and the same-cycle offer
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h500 + 32'(4 * i); in_instr = 32'h5000 + 32'(i);
      tick();
    end
    flush = 1'b1; in_pc = 32'h600; in_instr = 32'h6000; out_ready = 1'b1;
    #1;
    chk("fl_out_valid_now", 32'(out_valid), 32'd0);
    chk("fl_in_ready_now", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'h777;
    tick();
    in_valid = 1'b0;
    #1;
    chk("fl_redirect_pc", out_pc, 32'h100);
    chk("fl_redirect_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("fl_pop_empty", 32'(empty), 32'd1);

    // 6. stall holds the head stable
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h104; in_instr = 32'h00A00093;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_pc", out_pc, 32'h104);
      chk("stall_instr", out_instr, 32'h00A00093);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("stall_empty", 32'(empty), 32'd1);

    // empty push with decode ready
    in_valid = 1'b1; in_pc = 32'h800; in_instr = 32'h55;
    #1;
`ifdef FETCH_BUF_BYPASS_EN
    chk("byp_valid", 32'(out_valid), 32'd1);
    chk("byp_pc", out_pc, 32'h800);
    chk("byp_instr", out_instr, 32'h55);
    tick();
    in_valid = 1'b0;
    #1;
    chk("byp_count", 32'(count), 32'd0);
`else
    chk("nobyp_valid", 32'(out_valid), 32'd0);
    chk("nobyp_instr", out_instr, 32'h13);
    tick();
    in_valid = 1'b0;
    #1;
    chk("nobyp_count", 32'(count), 32'd1);
    chk("nobyp_pc", out_pc, 32'h800);
    tick();
    chk("nobyp_empty", 32'(empty), 32'd1);
`endif

    // reset mid-operation
    out_ready = 1'b0; in_valid = 1'b1;
    in_pc = 32'h900; tick();
    in_pc = 32'h904; tick();
    in_valid = 1'b0; reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_pc", out_pc, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
